wish_burst_master: RTL and testbench
====================================

Name: wish_burst_master

Overview:
- Command-driven block-transfer initiator for the 16-bit word memory port served by the SDRAM Wishbone responder.
- Accepts one command (byte address, word count, direction) and runs one single-word memory cycle per word, incrementing the address.
- Streams write data in and read data out over valid/ready.
- Sits between a DMA/framebuffer client and the memory responder.

Parameters:
- LEN_W, 16, width of the word-count field; max burst 2^LEN_W-1 words.
- TIMEOUT, 1024, cycles allowed per word, from request to completion, before the command aborts.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high in IDLE only
- cmd_addr  in  32  start byte address; bit 0 ignored, forced to 0
- cmd_len  in  LEN_W  word count
- cmd_write  in  1  1 = write burst, 0 = read burst
- wr_valid  in  1  / wr_ready  out  1  / wr_data  in  16  write-data stream
- rd_valid  out  1  / rd_ready  in  1  / rd_data  out  16  read-data stream
- done  out  1  one-cycle pulse when a command ends
- err  out  1  qualifies done; 1 = aborted on timeout
- m_stb  out  1  request strobe to responder
- m_we  out  1  direction to responder: 0 = write, 1 = read
- m_addr  out  32  byte address to responder
- m_dat  out  16  write data to responder
- s_cyc  in  1  responder cycle/busy
- s_stb  in  1  responder accept pulse
- s_dat  in  16  responder read data

Behaviour:
- Reset (async, any state): state IDLE. All outputs 0 except cmd_ready=1. Word counter, address and timeout counter cleared. A reset mid-burst drops the burst silently; no done is issued.
- IDLE:
  - cmd_ready=1. On cmd_valid: latch addr {cmd_addr[31:1],1'b0}, len and dir.
  - len==0: go to DONE with err=0; no memory cycle.
  - Otherwise go to FETCH for a write, REQ for a read.
- FETCH (write only): wr_ready=1. On wr_valid, latch wr_data into m_dat and go to REQ. Waiting here has no timeout.
- REQ:
  - m_stb=1, m_we=~dir, m_addr=current address.
  - The responder accepts with s_stb=1 (s_cyc rises on the same edge). On s_stb, drop m_stb next cycle and go to WAIT.
  - s_cyc high without s_stb means the responder is busy; keep m_stb asserted.
- WAIT: word completes on the first cycle with s_cyc=0.
  - Read: capture s_dat into rd_data and go to PUSH.
  - Write: go to NEXT.
- PUSH: rd_valid=1 and rd_data held stable until rd_ready. Leave on the handshake edge to NEXT. No timeout in PUSH.
- NEXT: address += 2 (wraps modulo 2^32); count -= 1. If count==0 go to DONE; else go to FETCH (write) or REQ (read).
- DONE: done=1 for one cycle with err valid, then IDLE. err is held until the next command is accepted.
- Timeout:
  - Counter clears on entry to REQ and counts in REQ and WAIT.
  - Reaching TIMEOUT: drop m_stb, set err=1, go to DONE.
  - Words already streamed stay delivered.
- Simultaneous events:
  - s_stb and s_cyc=0 in the same cycle in REQ counts as accept only; completion is evaluated from the next cycle.
  - A timeout and an accept in the same cycle: the accept wins.
- Exactly one memory cycle is outstanding at any time. m_addr, m_we and m_dat are stable from REQ entry through WAIT.

Decomposition:
- Package wish_mem_pkg:
  - state enum (IDLE, FETCH, REQ, WAIT, PUSH, NEXT, DONE)
  - WORD_W=16, ADDR_W=32, BYTES_PER_WORD=2
  - m_we encoding constants WE_WRITE=0, WE_READ=1
- Sub-module wish_timeout_cnt: clear/enable in, expired out.
- Responder model for the bench: wish_mem_model.

Test Plan:
- Write burst: addr 0x100, len 3, data 0xA1,0xA2,0xA3, responder accepts after 2 cycles -> m_addr 0x100,0x102,0x104 with m_we=0; model holds the data; single done with err=0.
- Read burst: addr 0x201, len 2, model data 0x55AA,0x1234, rd_ready held low 5 cycles -> m_addr 0x200,0x202; rd_data stable under backpressure; done after the second handshake.
- Busy responder: s_cyc=1 for 10 cycles before s_stb -> m_stb held the whole time; exactly one accept per word.
- Timeout: TIMEOUT=16, responder never asserts s_stb -> m_stb drops at cycle 16; done=1 with err=1; cmd_ready=1 the next cycle.
- len=0 command -> done pulse 1 cycle after accept; m_stb never asserted.
- Async reset asserted in WAIT of word 2 of 4 -> outputs go to reset values immediately, no done; a new command is accepted after release.

Source files
------------

// File: rtl/wish_mem_pkg.sv
// Shared types and constants for the 16-bit word Wishbone memory port.
// The state encoding, bus widths and m_we polarity live here so master and bench agree.
package wish_mem_pkg;

  localparam int WORD_W         = 16;
  localparam int ADDR_W         = 32;
  localparam int BYTES_PER_WORD = 2;

  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    REQ,
    WAIT,
    PUSH,
    NEXT,
    DONE
  } state_t;

  // Word-align a byte address by forcing bit 0 low.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/wish_timeout_cnt.sv
// Per-word watchdog: counts enabled cycles and flags the TIMEOUT-th one.
// Held at zero while clr is high; saturates once expired.
module wish_timeout_cnt #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !expired)
      cnt <= cnt + CW'(1);
  end

  // Asserted during the TIMEOUT-th enabled cycle so the abort lands on that edge.
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wish_burst_master.sv
// Block-transfer initiator: one single-word Wishbone cycle per word, address stepping by 2.
// Write data is pulled over wr_valid/wr_ready, read data pushed over rd_valid/rd_ready.
module wish_burst_master
  import wish_mem_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_write,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_dat,
  input  logic              s_cyc,
  input  logic              s_stb,
  input  logic [WORD_W-1:0] s_dat
);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              we_q;
  logic [WORD_W-1:0] m_dat_q;
  logic [WORD_W-1:0] rd_data_q;
  logic              err_q;
  logic              tmo_clr;
  logic              tmo_expired;
  logic              tmo_abort;

  assign tmo_clr = !(state == REQ || state == WAIT);

  wish_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (tmo_clr),
    .en      (!tmo_clr),
    .expired (tmo_expired)
  );

  // An accept in REQ or a completion in WAIT beats an expiry in the same cycle.
  assign tmo_abort = tmo_expired && ((state == REQ && !s_stb) || (state == WAIT && s_cyc));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0)
            state_d = DONE;
          else if (cmd_write)
            state_d = FETCH;
          else
            state_d = REQ;
        end
      end
      FETCH: if (wr_valid) state_d = REQ;
      REQ: begin
        if (s_stb)
          state_d = WAIT;
        else if (tmo_abort)
          state_d = DONE;
      end
      WAIT: begin
        if (!s_cyc)
          state_d = (we_q == WE_READ) ? PUSH : NEXT;
        else if (tmo_abort)
          state_d = DONE;
      end
      PUSH: if (rd_ready) state_d = NEXT;
      NEXT: begin
        if (len_q == LEN_W'(1))
          state_d = DONE;
        else
          state_d = (we_q == WE_WRITE) ? FETCH : REQ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    m_stb     = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      FETCH:   wr_ready  = 1'b1;
      REQ:     m_stb     = 1'b1;
      PUSH:    rd_valid  = 1'b1;
      DONE:    done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      len_q     <= '0;
      we_q      <= WE_WRITE;
      m_dat_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        addr_q <= word_align(cmd_addr);
        len_q  <= cmd_len;
        we_q   <= cmd_write ? WE_WRITE : WE_READ;
        err_q  <= 1'b0;
      end
      if (state == FETCH && wr_valid)
        m_dat_q <= wr_data;
      if (state == WAIT && !s_cyc && we_q == WE_READ)
        rd_data_q <= s_dat;
      if (state == NEXT) begin
        addr_q <= addr_q + ADDR_W'(BYTES_PER_WORD);
        len_q  <= len_q - LEN_W'(1);
      end
      if (tmo_abort)
        err_q <= 1'b1;
    end
  end

  assign m_addr  = addr_q;
  assign m_we    = we_q;
  assign m_dat   = m_dat_q;
  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_wish_burst_master.sv
// Randomized scoreboard bench for wish_burst_master with a behavioural Wishbone responder.
module tb_wish_burst_master;
  import wish_mem_pkg::*;

  localparam int LEN_W = 16;
  localparam int TMO   = 16;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0]       cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wr_valid, wr_ready, rd_valid, rd_ready, done, err;
  logic [15:0]       wr_data, rd_data, m_dat, s_dat;
  logic              m_stb, m_we, s_cyc, s_stb;
  logic [31:0]       m_addr;

  wish_burst_master #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_write(cmd_write),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_dat(m_dat),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_dat(s_dat)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: expected bus accepts, read words and done/err outcomes per command.
  typedef struct { logic [31:0] addr; logic we; logic [15:0] dat; } acc_t;
  acc_t        exp_acc[$];
  logic [15:0] exp_rd[$];
  logic        exp_done[$];
  logic [15:0] wdata_in[$];
  logic [15:0] wr_q[$];
  logic [15:0] mem     [logic [31:0]];
  logic [15:0] ref_mem [logic [31:0]];

  function automatic logic [15:0] dflt(input logic [31:0] a);
    return a[16:1] ^ 16'h5A5A;
  endfunction

  // Responder (wish_mem_model): configurable busy and completion latency per word.
  int busy_lo = 0, busy_hi = 0, wt_lo = 0, wt_hi = 0;
  bit no_resp = 0, resp_busy = 0;
  int acc_cnt = 0, stb_cycles = 0;

  initial begin : wish_mem_model
    int nb, nw;
    logic [31:0] a;
    logic w;
    logic [15:0] d;
    acc_t e;
    s_cyc = 0; s_stb = 0; s_dat = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && m_stb && !no_resp) begin
        resp_busy = 1;
        nb = $urandom_range(busy_hi, busy_lo);
        nw = $urandom_range(wt_hi, wt_lo);
        for (int i = 0; i < nb; i++) begin
          s_cyc = 1;
          @(negedge clk_i);
          chk("m_stb_held_busy", m_stb, 1);
        end
        a = m_addr; w = m_we; d = m_dat;
        s_stb = 1; s_cyc = 1;
        acc_cnt++;
        chk("accept_expected", exp_acc.size() > 0, 1);
        if (exp_acc.size() > 0) begin
          e = exp_acc.pop_front();
          chk("m_addr", a, e.addr);
          chk("m_we", w, e.we);
          if (e.we == WE_WRITE) chk("m_dat", d, e.dat);
        end
        if (w == WE_WRITE) mem[a] = d;
        @(negedge clk_i);
        s_stb = 0;
        for (int i = 0; i < nw; i++) begin
          @(negedge clk_i);
          if (!rst_i) chk("m_addr_stable_wait", m_addr, a);
        end
        s_cyc = 0;
        s_dat = (w == WE_READ) ? (mem.exists(a) ? mem[a] : dflt(a)) : 16'h0;
        resp_busy = 0;
      end
    end
  end

  // Read-side consumer: random ready, or a fixed stall of rd_hold cycles per word.
  int rd_hold = -1;
  initial begin : rd_drv
    int h;
    h = 0; rd_ready = 0;
    forever begin
      @(posedge clk_i); #1;
      if (rd_hold < 0) rd_ready = 1'($urandom_range(0, 1));
      else if (!rd_valid) begin h = 0; rd_ready = 0; end
      else if (h < rd_hold) begin h++; rd_ready = 0; end
      else rd_ready = 1;
    end
  end

  bit wr_taken = 0;
  initial begin : wr_drv
    wr_valid = 0; wr_data = 0;
    forever begin
      @(posedge clk_i); #1;
      if (wr_taken) begin
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        wr_taken = 0; wr_valid = 0;
      end
      if (!wr_valid && wr_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        wr_valid = 1; wr_data = wr_q[0];
      end
    end
  end

  // Monitor: read stream, done/err and strobe activity.
  initial begin : monitor
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (wr_valid && wr_ready) wr_taken = 1;
        if (m_stb) stb_cycles++;
        if (rd_valid) begin
          chk("rd_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) begin
            if (rd_ready) chk("rd_data", rd_data, exp_rd.pop_front());
            else          chk("rd_data_held", rd_data, exp_rd[0]);
          end
        end
        if (done) begin
          chk("done_expected", exp_done.size() > 0, 1);
          if (exp_done.size() > 0) begin
            chk("err", err, exp_done.pop_front());
            chk("rd_drained_at_done", exp_rd.size(), 0);
            chk("acc_drained_at_done", exp_acc.size(), 0);
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input int len, input bit wr, input bit exp_err);
    logic [31:0] base;
    acc_t e;
    int t;
    base = {addr[31:1], 1'b0};
    for (int i = 0; i < len; i++) begin
      e.addr = base + 32'(2 * i);
      e.we   = wr ? WE_WRITE : WE_READ;
      e.dat  = 16'h0;
      if (!exp_err) begin
        if (wr) begin
          e.dat = (wdata_in.size() > 0) ? wdata_in.pop_front() : 16'($urandom);
          wr_q.push_back(e.dat);
          ref_mem[e.addr] = e.dat;
        end else begin
          exp_rd.push_back(ref_mem.exists(e.addr) ? ref_mem[e.addr] : dflt(e.addr));
        end
        exp_acc.push_back(e);
      end
    end
    exp_done.push_back(exp_err);
    @(posedge clk_i); #1;
    cmd_addr = addr; cmd_len = LEN_W'(len); cmd_write = wr; cmd_valid = 1;
    t = 0;
    while (t < 200) begin
      @(negedge clk_i);
      if (cmd_ready) break;
      t++;
    end
    chk("cmd_accepted_in_bound", t < 200, 1);
    @(posedge clk_i); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (t < 3000) begin
      @(negedge clk_i);
      if (done) break;
      t++;
    end
    chk("done_within_bound", t < 3000, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((resp_busy || !cmd_ready) && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    chk("idle_within_bound", t < 200, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_m_stb"}, m_stb, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_dat"}, m_dat, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin : main
    int snap;
    repeat (3) @(negedge clk_i);
    chk_reset_outputs("reset");
    rst_i = 0;
    repeat (2) @(negedge clk_i);

    // Write burst with a 2-cycle accept delay.
    busy_lo = 2; busy_hi = 2; wt_lo = 0; wt_hi = 1;
    wdata_in = '{16'h00A1, 16'h00A2, 16'h00A3};
    issue(32'h100, 3, 1, 0);
    wait_done();
    wait_idle();
    chk("mem_100", mem.exists(32'h100) ? mem[32'h100] : 16'hDEAD, 16'h00A1);
    chk("mem_102", mem.exists(32'h102) ? mem[32'h102] : 16'hDEAD, 16'h00A2);
    chk("mem_104", mem.exists(32'h104) ? mem[32'h104] : 16'hDEAD, 16'h00A3);

    // Read burst from an odd address under 5-cycle read backpressure.
    mem[32'h200] = 16'h55AA; ref_mem[32'h200] = 16'h55AA;
    mem[32'h202] = 16'h1234; ref_mem[32'h202] = 16'h1234;
    busy_lo = 0; busy_hi = 1; rd_hold = 5;
    issue(32'h201, 2, 0, 0);
    wait_done();
    wait_idle();
    rd_hold = -1;

    // Responder busy for 10 cycles before each accept.
    busy_lo = 10; busy_hi = 10; wt_lo = 0; wt_hi = 0;
    snap = acc_cnt;
    issue(32'h0000_1230, 2, 0, 0);
    wait_done();
    wait_idle();
    chk("busy_accepts", acc_cnt - snap, 2);

    // Responder never accepts: abort after TMO cycles of strobe.
    no_resp = 1;
    snap = stb_cycles;
    issue(32'h300, 1, 0, 1);
    wait_done();
    @(negedge clk_i);
    chk("tmo_stb_cycles", stb_cycles - snap, TMO);
    chk("tmo_cmd_ready_after", cmd_ready, 1);
    chk("tmo_err_held", err, 1);
    no_resp = 0;

    // Zero-length command: done one cycle after accept, no strobe.
    snap = stb_cycles;
    issue(32'h500, 0, 1, 0);
    @(negedge clk_i);
    chk("len0_done", done, 1);
    chk("len0_err_cleared", err, 0);
    @(negedge clk_i);
    chk("len0_done_one_cycle", done, 0);
    chk("len0_no_stb", stb_cycles - snap, 0);

    // Address wrap across 2^32.
    busy_lo = 0; busy_hi = 2; wt_lo = 0; wt_hi = 2;
    issue(32'hFFFF_FFFD, 4, 1, 0);
    wait_done();
    wait_idle();
    issue(32'hFFFF_FFFC, 4, 0, 0);
    wait_done();
    wait_idle();

    // Randomized commands.
    busy_lo = 0; busy_hi = 4; wt_lo = 0; wt_hi = 4;
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a;
      a = {16'h0000, 4'h1, 12'($urandom_range(0, 4095))};
      issue(a, $urandom_range(1, 6), 1'($urandom_range(0, 1)), 0);
      wait_done();
      wait_idle();
    end

    // Reset during the completion wait of word 2 of 4.
    busy_lo = 0; busy_hi = 0; wt_lo = 8; wt_hi = 8;
    snap = acc_cnt;
    issue(32'h400, 4, 1, 0);
    begin
      int t;
      t = 0;
      while (acc_cnt < snap + 2 && t < 500) begin @(negedge clk_i); t++; end
      chk("rst_reached_word2", acc_cnt - snap, 2);
    end
    repeat (2) @(negedge clk_i);
    #2;
    rst_i = 1;
    exp_acc.delete(); exp_done.delete(); exp_rd.delete();
    wr_q.delete(); wr_valid = 0; wr_taken = 0;
    #1;
    chk_reset_outputs("midburst_reset");
    begin
      int t;
      t = 0;
      while (resp_busy && t < 100) begin @(negedge clk_i); t++; end
      chk("resp_idle_in_reset", resp_busy, 0);
    end
    @(negedge clk_i);
    rst_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("no_done_after_reset", done, 0);
    end
    wt_lo = 0; wt_hi = 2;
    issue(32'h400, 2, 0, 0);
    wait_done();
    wait_idle();

    chk("final_acc_empty", exp_acc.size(), 0);
    chk("final_rd_empty", exp_rd.size(), 0);
    chk("final_done_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
